// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding
// and the EX operand forwarding select codes.
package pipe_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        DIV  = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of hazard inputs and pipeline control outputs between the core
// datapath (master) and the hazard controller (slave).
interface pipe_ctrl_if #(
    parameter int REG_W = 5
);
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic [REG_W-1:0] ex_rs1;
    logic [REG_W-1:0] ex_rs2;
    logic [REG_W-1:0] ex_rd;
    logic             ex_is_load;
    logic             ex_div;
    logic             ex_branch_taken;
    logic [REG_W-1:0] mem_rd;
    logic [REG_W-1:0] wb_rd;
    logic             mem_reg_write;
    logic             wb_reg_write;
    logic             dmem_req;
    logic             dmem_ready;

    logic             pc_en;
    logic             en_if_id;
    logic             en_id_ex;
    logic             en_ex_mem;
    logic             en_mem_wb;
    logic             clr_if_id;
    logic             clr_id_ex;
    logic             clr_ex_mem;
    logic             clr_mem_wb;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             div_busy;
    logic [31:0]      stall_cycles;

    modport master (
        output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_is_load, ex_div,
               ex_branch_taken, mem_rd, wb_rd, mem_reg_write, wb_reg_write,
               dmem_req, dmem_ready,
        input  pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
               clr_if_id, clr_id_ex, clr_ex_mem, clr_mem_wb,
               fwd_a, fwd_b, div_busy, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_is_load, ex_div,
               ex_branch_taken, mem_rd, wb_rd, mem_reg_write, wb_reg_write,
               dmem_req, dmem_ready,
        output pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
               clr_if_id, clr_id_ex, clr_ex_mem, clr_mem_wb,
               fwd_a, fwd_b, div_busy, stall_cycles
    );

endinterface

// File: rtl/pipe_ctrl_fwd_unit.sv
// EX operand forwarding select: the younger MEM result wins over WB, and
// register x0 is never forwarded because it always reads as zero.
module fwd_unit
    import pipe_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] ex_rs1_i,
    input  logic [REG_W-1:0] ex_rs2_i,
    input  logic [REG_W-1:0] mem_rd_i,
    input  logic [REG_W-1:0] wb_rd_i,
    input  logic             mem_reg_write_i,
    input  logic             wb_reg_write_i,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o
);

    // Operand A select, MEM match takes precedence over WB match
    always_comb begin
        fwd_a_o = FWD_RF;
        if (ex_rs1_i != '0) begin
            if (mem_reg_write_i && (mem_rd_i == ex_rs1_i)) begin
                fwd_a_o = FWD_MEM;
            end else if (wb_reg_write_i && (wb_rd_i == ex_rs1_i)) begin
                fwd_a_o = FWD_WB;
            end
        end
    end

    // Operand B select, same priority as operand A
    always_comb begin
        fwd_b_o = FWD_RF;
        if (ex_rs2_i != '0) begin
            if (mem_reg_write_i && (mem_rd_i == ex_rs2_i)) begin
                fwd_b_o = FWD_MEM;
            end else if (wb_reg_write_i && (wb_rd_i == ex_rs2_i)) begin
                fwd_b_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: drives the
// inter-stage register enables/clears and PC enable, resolves load-use,
// branch, divide and data-memory stalls, and counts stall cycles.
// Optional feature macro: PIPE_CTRL_DIV_EN adds the multi-cycle divide
// state, its counter and div_busy; without it ex_div is ignored.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int DIV_CYCLES = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    pipe_ctrl_if.slave bus
);

    state_e      state_q, state_d;
    logic [31:0] stall_q, stall_d;
    logic        memWait;
    logic        loadUse;
    logic        inDiv;
    logic        pcEn;
    logic [3:0]  en;
    logic [3:0]  clr;
    logic [1:0]  rawFwdA;
    logic [1:0]  rawFwdB;

    assign memWait = bus.dmem_req && !bus.dmem_ready;
    assign loadUse = bus.ex_is_load && (bus.ex_rd != '0) &&
                     ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));

`ifdef PIPE_CTRL_DIV_EN
    localparam int CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             divDone_q, divDone_d;

    assign inDiv = (state_q == DIV);

    // Next state, divide countdown and the one-shot release flag; the
    // countdown pauses while memory stalls so the freeze stretches with it
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        divDone_d = 1'b0;
        case (state_q)
            INIT: state_d = RUN;
            RUN: begin
                divDone_d = divDone_q && memWait;
                if (bus.ex_div && !divDone_q && !memWait) begin
                    state_d = DIV;
                    cnt_d   = CNT_W'(DIV_CYCLES - 2);
                end
            end
            DIV: begin
                if (!memWait) begin
                    if (cnt_q == '0) begin
                        state_d   = RUN;
                        divDone_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    // Divide counter and release flag, abandoned on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            divDone_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            divDone_q <= divDone_d;
        end
    end

    assign bus.div_busy = inDiv;
`else
    logic unusedDiv;

    assign inDiv     = 1'b0;
    assign unusedDiv = bus.ex_div & (DIV_CYCLES >= 2);

    // Next state without a divider: one INIT cycle, then RUN forever
    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    assign bus.div_busy = 1'b0;
`endif

    // Pipeline control by priority: init, memory wait, divide, branch, load-use
    always_comb begin
        pcEn = 1'b1;
        en   = 4'b1111;
        clr  = 4'b0000;
        if (state_q == INIT) begin
            pcEn = 1'b0;
            clr  = 4'b1111;
        end else if (memWait) begin
            pcEn = 1'b0;
            en   = 4'b0000;
        end else if (inDiv) begin
            pcEn = 1'b0;
            en   = 4'b0011;
            clr  = 4'b0010;
        end else if (bus.ex_branch_taken) begin
            clr  = 4'b1100;
        end else if (loadUse) begin
            pcEn = 1'b0;
            en   = 4'b0111;
            clr  = 4'b0100;
        end
    end

    // Saturating count of cycles where the PC is held, ignoring INIT
    always_comb begin
        stall_d = stall_q;
        if ((state_q != INIT) && !pcEn && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // FSM state and stall counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    fwd_unit #(
        .REG_W(REG_W)
    ) u_fwd (
        .ex_rs1_i       (bus.ex_rs1),
        .ex_rs2_i       (bus.ex_rs2),
        .mem_rd_i       (bus.mem_rd),
        .wb_rd_i        (bus.wb_rd),
        .mem_reg_write_i(bus.mem_reg_write),
        .wb_reg_write_i (bus.wb_reg_write),
        .fwd_a_o        (rawFwdA),
        .fwd_b_o        (rawFwdB)
    );

    assign bus.fwd_a        = (state_q == INIT) ? FWD_RF : rawFwdA;
    assign bus.fwd_b        = (state_q == INIT) ? FWD_RF : rawFwdB;
    assign bus.pc_en        = pcEn;
    assign bus.en_if_id     = en[3];
    assign bus.en_id_ex     = en[2];
    assign bus.en_ex_mem    = en[1];
    assign bus.en_mem_wb    = en[0];
    assign bus.clr_if_id    = clr[3];
    assign bus.clr_id_ex    = clr[2];
    assign bus.clr_ex_mem   = clr[1];
    assign bus.clr_mem_wb   = clr[0];
    assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each stimulus cycle queues its expected
// controls, forwarding selects, div_busy and stall count; a negedge monitor
// pops and compares. Divide sequences run when PIPE_CTRL_DIV_EN is defined.
module tb_pipe_ctrl;
    import pipe_pkg::*;

    localparam int REG_W      = 5;
    localparam int DIV_CYCLES = 32;

    // {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, clr_if_id, clr_id_ex, clr_ex_mem, clr_mem_wb}
    localparam logic [8:0] C_INIT = 9'b0_1111_1111;
    localparam logic [8:0] C_NORM = 9'b1_1111_0000;
    localparam logic [8:0] C_LU   = 9'b0_0111_0100;
    localparam logic [8:0] C_BR   = 9'b1_1111_1100;
    localparam logic [8:0] C_WAIT = 9'b0_0000_0000;
    localparam logic [8:0] C_DIV  = 9'b0_0011_0010;

    typedef struct {
        string       name;
        logic [8:0]  ctl;
        logic [1:0]  fwdA;
        logic [1:0]  fwdB;
        logic        busy;
        logic [31:0] stall;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] expStall = '0;

    pipe_ctrl_if #(.REG_W(REG_W)) bus ();

    pipe_ctrl #(
        .REG_W     (REG_W),
        .DIV_CYCLES(DIV_CYCLES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic clearIns();
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.ex_rs1 = '0; bus.ex_rs2 = '0;
        bus.ex_rd = '0; bus.ex_is_load = 1'b0; bus.ex_div = 1'b0;
        bus.ex_branch_taken = 1'b0; bus.mem_rd = '0; bus.wb_rd = '0;
        bus.mem_reg_write = 1'b0; bus.wb_reg_write = 1'b0;
        bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
    endtask

    // Queue the expectation for the cycle just driven, then advance one cycle
    task automatic applyStimulus(input string nm, input logic [8:0] ctl,
                                 input logic [1:0] fa, input logic [1:0] fb,
                                 input logic busy);
        exp_t e;
        e.name  = nm;
        e.ctl   = ctl;
        e.fwdA  = fa;
        e.fwdB  = fb;
        e.busy  = busy;
        e.stall = expStall;
        sb.push_back(e);
        if (!ctl[8] && (ctl != C_INIT)) expStall = expStall + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOne(input string nm, input string field,
                            input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s.%s got=%0h want=%0h t=%0t", nm, field, got, want, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        logic [8:0] ctlGot;
        ctlGot = {bus.pc_en, bus.en_if_id, bus.en_id_ex, bus.en_ex_mem, bus.en_mem_wb,
                  bus.clr_if_id, bus.clr_id_ex, bus.clr_ex_mem, bus.clr_mem_wb};
        checkOne(e.name, "ctl", {23'd0, ctlGot}, {23'd0, e.ctl});
        checkOne(e.name, "fwd", {28'd0, bus.fwd_a, bus.fwd_b}, {28'd0, e.fwdA, e.fwdB});
        checkOne(e.name, "div_busy", {31'd0, bus.div_busy}, {31'd0, e.busy});
        checkOne(e.name, "stall_cycles", bus.stall_cycles, e.stall);
    endtask

    // Monitor: compare the DUT against the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput(e);
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        clearIns();
        @(posedge clk);
        #1;

        applyStimulus("reset_hold0", C_INIT, 2'b00, 2'b00, 1'b0);
        applyStimulus("reset_hold1", C_INIT, 2'b00, 2'b00, 1'b0);
        rst_n = 1'b1;
        applyStimulus("init_cycle", C_INIT, 2'b00, 2'b00, 1'b0);
        applyStimulus("first_run", C_NORM, 2'b00, 2'b00, 1'b0);

        // load-use hazards
        bus.ex_is_load = 1'b1; bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5;
        applyStimulus("loaduse_rs2", C_LU, 2'b00, 2'b00, 1'b0);
        clearIns();
        applyStimulus("after_loaduse", C_NORM, 2'b00, 2'b00, 1'b0);
        bus.ex_is_load = 1'b1;
        applyStimulus("loaduse_x0", C_NORM, 2'b00, 2'b00, 1'b0);
        bus.ex_rd = 5'd9; bus.id_rs1 = 5'd9;
        applyStimulus("loaduse_rs1", C_LU, 2'b00, 2'b00, 1'b0);
        bus.id_rs1 = 5'd4; bus.id_rs2 = 5'd3;
        applyStimulus("load_nomatch", C_NORM, 2'b00, 2'b00, 1'b0);
        clearIns();
        bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5;
        applyStimulus("alu_nomatch", C_NORM, 2'b00, 2'b00, 1'b0);

        // branches, including one colliding with a load-use match
        bus.ex_is_load = 1'b1; bus.ex_branch_taken = 1'b1;
        applyStimulus("branch_over_lu", C_BR, 2'b00, 2'b00, 1'b0);
        clearIns();
        bus.ex_branch_taken = 1'b1;
        applyStimulus("branch_only", C_BR, 2'b00, 2'b00, 1'b0);
        clearIns();
        applyStimulus("after_branch", C_NORM, 2'b00, 2'b00, 1'b0);

        // forwarding
        bus.mem_rd = 5'd7; bus.wb_rd = 5'd7; bus.mem_reg_write = 1'b1;
        bus.wb_reg_write = 1'b1; bus.ex_rs1 = 5'd7;
        applyStimulus("fwd_a_mem", C_NORM, 2'b01, 2'b00, 1'b0);
        bus.mem_reg_write = 1'b0;
        applyStimulus("fwd_a_wb", C_NORM, 2'b10, 2'b00, 1'b0);
        bus.ex_rs1 = 5'd0;
        applyStimulus("fwd_a_rf", C_NORM, 2'b00, 2'b00, 1'b0);
        bus.mem_reg_write = 1'b1; bus.mem_rd = 5'd0; bus.wb_rd = 5'd0;
        applyStimulus("fwd_x0", C_NORM, 2'b00, 2'b00, 1'b0);
        bus.mem_rd = 5'd3; bus.wb_rd = 5'd3; bus.ex_rs1 = 5'd3; bus.ex_rs2 = 5'd3;
        applyStimulus("fwd_both_mem", C_NORM, 2'b01, 2'b01, 1'b0);
        bus.mem_rd = 5'd4;
        applyStimulus("fwd_both_wb", C_NORM, 2'b10, 2'b10, 1'b0);
        bus.ex_rs1 = 5'd4;
        applyStimulus("fwd_split", C_NORM, 2'b01, 2'b10, 1'b0);
        clearIns();

        // memory wait states
        bus.dmem_req = 1'b1;
        applyStimulus("mem_wait0", C_WAIT, 2'b00, 2'b00, 1'b0);
        bus.ex_is_load = 1'b1; bus.ex_rd = 5'd6; bus.id_rs1 = 5'd6;
        applyStimulus("wait_over_lu", C_WAIT, 2'b00, 2'b00, 1'b0);
        clearIns();
        bus.dmem_req = 1'b1; bus.dmem_ready = 1'b1;
        applyStimulus("mem_ready", C_NORM, 2'b00, 2'b00, 1'b0);
        clearIns();

`ifdef PIPE_CTRL_DIV_EN
        // plain divide
        bus.ex_div = 1'b1;
        applyStimulus("div_enter", C_NORM, 2'b00, 2'b00, 1'b0);
        for (int i = 0; i < DIV_CYCLES - 1; i++)
            applyStimulus("div_freeze", C_DIV, 2'b00, 2'b00, 1'b1);
        applyStimulus("div_release", C_NORM, 2'b00, 2'b00, 1'b0);
        bus.ex_div = 1'b0;
        applyStimulus("div_no_reentry", C_NORM, 2'b00, 2'b00, 1'b0);

        // divide held off by a wait, then stretched by a 3-cycle wait
        bus.ex_div = 1'b1; bus.dmem_req = 1'b1;
        applyStimulus("div_entry_wait", C_WAIT, 2'b00, 2'b00, 1'b0);
        bus.dmem_req = 1'b0;
        applyStimulus("div_enter2", C_NORM, 2'b00, 2'b00, 1'b0);
        for (int i = 0; i < 10; i++)
            applyStimulus("div2_freeze_a", C_DIV, 2'b00, 2'b00, 1'b1);
        bus.dmem_req = 1'b1;
        for (int i = 0; i < 3; i++)
            applyStimulus("div2_memwait", C_WAIT, 2'b00, 2'b00, 1'b1);
        bus.dmem_req = 1'b0;
        for (int i = 0; i < DIV_CYCLES - 11; i++)
            applyStimulus("div2_freeze_b", C_DIV, 2'b00, 2'b00, 1'b1);
        applyStimulus("div2_release", C_NORM, 2'b00, 2'b00, 1'b0);
        bus.ex_div = 1'b0;
        applyStimulus("div2_after", C_NORM, 2'b00, 2'b00, 1'b0);

        // abandon a divide in flight
        bus.ex_div = 1'b1;
        applyStimulus("div_enter3", C_NORM, 2'b00, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus("div3_freeze", C_DIV, 2'b00, 2'b00, 1'b1);
`else
        bus.ex_div = 1'b1;
        for (int i = 0; i < 3; i++)
            applyStimulus("div_ignored", C_NORM, 2'b00, 2'b00, 1'b0);
`endif

        // asynchronous reset mid-run
        clearIns();
        rst_n = 1'b0;
        expStall = '0;
        applyStimulus("reset_mid", C_INIT, 2'b00, 2'b00, 1'b0);
        rst_n = 1'b1;
        applyStimulus("init_again", C_INIT, 2'b00, 2'b00, 1'b0);
        applyStimulus("run_again", C_NORM, 2'b00, 2'b00, 1'b0);
        bus.ex_is_load = 1'b1; bus.ex_rd = 5'd2; bus.id_rs1 = 5'd2;
        applyStimulus("loaduse_after_rst", C_LU, 2'b00, 2'b00, 1'b0);
        clearIns();
        applyStimulus("final_run", C_NORM, 2'b00, 2'b00, 1'b0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain got=%0d want=0 pending", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
